// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the counter family (loadable up-counter,
// down-counter/timer). Holds the control-state encoding and the default
// counter width so every member agrees on both.
//
// Contents:
//   COUNTER_WIDTH    default counter / parallel-load width in bits
//   counter_state_e  control state: IDLE, RUN, DONE
//   is_zero()        helper: 1 when a counter value is all zeros
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } counter_state_e;

    // Zero test kept width-agnostic so callers can pass any counter width
    // up to 32 bits without writing their own reduction.
    function automatic logic is_zero(input logic [31:0] value);
        return (value == 32'd0);
    endfunction

endpackage : counter_pkg

// File: rtl/down_counter_timer.sv
// ----------------------------------------------------------------------------
// down_counter_timer
//
// Loadable down-counter / timer. A preset is parallel-loaded (same format the
// loadable up-counter produces), then counted down to zero on enabled edges.
// Reaching zero produces a one-clock terminal-count pulse. In one-shot mode
// the timer then parks in DONE; with auto-reload it refills from the reload
// register on the next enabled edge and keeps running as a periodic ticker.
//
// Parameters:
//   WIDTH      counter and load width in bits (>= 2)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   load       parallel load of d into count and reload registers
//   d          value to load
//   start      begin / resume counting (level sampled per edge)
//   stop       pause counting, count held
//   en         count enable; RUN only advances on edges with en=1
//   reload_en  1 = periodic (auto-reload at zero), 0 = one-shot
//   q          current count (registered)
//   busy       1 while in RUN (decoded from the state register)
//   tc         terminal-count pulse, one clk wide (registered)
//   done       one-shot finished; held until load or start
//
// Per-edge priority: rst > load > stop > start > count.
// ----------------------------------------------------------------------------
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             reload_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    counter_state_e   state;
    logic [WIDTH-1:0] rld;

    logic q_zero;
    logic rld_zero;

    assign q_zero   = is_zero(32'(q));
    assign rld_zero = is_zero(32'(rld));

    // busy is a pure decode of the state register, so it changes only on
    // clock edges (or reset) and has no path from any input.
    assign busy = (state == RUN);

    // NOTE: all state lives in one clocked block with non-blocking
    // assignments, so every register samples pre-edge values and the
    // "default then override" pattern below (tc) is race-free.
    // NOTE: reset is asynchronous; every register, including the reload
    // register, has a defined reset value so a mid-count abort leaves no
    // stale preset behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            // tc is a single-cycle pulse: cleared on every edge unless the
            // 1 -> 0 transition below re-asserts it.
            tc <= 1'b0;

            if (load) begin
                q     <= d;
                rld   <= d;
                state <= IDLE;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A zero count has nothing to time, so start is
                        // ignored; stop outranks start on the same edge.
                        if (!stop && start && !q_zero) begin
                            state <= RUN;
                        end
                    end

                    RUN: begin
                        if (stop) begin
                            // Pause: q is held so a later start resumes.
                            state <= IDLE;
                        end else if (en) begin
                            if (q > ONE) begin
                                q <= q - ONE;
                            end else if (q == ONE) begin
                                q  <= '0;
                                tc <= 1'b1;
                                // reload_en is only consulted here, at the
                                // 1 -> 0 edge; changing it elsewhere is benign.
                                if (!reload_en) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                // q == 0 in RUN only happens in periodic
                                // mode: the zero state lasts one enabled edge,
                                // giving a period of preset+1 enabled edges.
                                q <= rld;
                            end
                        end
                    end

                    DONE: begin
                        if (!stop && start && !rld_zero) begin
                            q     <= rld;
                            done  <= 1'b0;
                            state <= RUN;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// ----------------------------------------------------------------------------
// tb_down_counter_timer
//
// Self-checking bench for down_counter_timer (WIDTH = 4). Expected outputs
// come from a behavioural model that tracks the count, the stored preset and
// two flags (running / finished) and applies the timer's rules directly.
// ----------------------------------------------------------------------------
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       reload_en = 1'b0;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [3:0] m_q;
    logic [3:0] m_rld;
    bit         m_running;
    bit         m_done;
    bit         m_tc;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d         (d),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .reload_en (reload_en),
        .q         (q),
        .busy      (busy),
        .tc        (tc),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q       = 4'd0;
        m_rld     = 4'd0;
        m_running = 1'b0;
        m_done    = 1'b0;
        m_tc      = 1'b0;
    endtask

    // Applies one rising edge worth of rules to the model, using the inputs
    // that were stable before the edge.
    task automatic model_edge();
        m_tc = 1'b0;
        if (load) begin
            m_q       = d;
            m_rld     = d;
            m_running = 1'b0;
            m_done    = 1'b0;
        end else if (m_running) begin
            if (stop) begin
                m_running = 1'b0;
            end else if (en) begin
                if (m_q == 4'd0) begin
                    m_q = m_rld;
                end else begin
                    m_q = m_q - 4'd1;
                    if (m_q == 4'd0) begin
                        m_tc = 1'b1;
                        if (!reload_en) begin
                            m_running = 1'b0;
                            m_done    = 1'b1;
                        end
                    end
                end
            end
        end else if (!stop && start) begin
            if (m_done) begin
                if (m_rld != 4'd0) begin
                    m_q       = m_rld;
                    m_done    = 1'b0;
                    m_running = 1'b1;
                end
            end else if (m_q != 4'd0) begin
                m_running = 1'b1;
            end
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, then settle 1
    // time unit past the edge so outputs are sampled away from it.
    task automatic step(input logic l, input logic [3:0] dv, input logic s,
                        input logic sp, input logic e, input logic r);
        load      = l;
        d         = dv;
        start     = s;
        stop      = sp;
        en        = e;
        reload_en = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset_pulse();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        // Power-on reset released between edges.
        #12;
        model_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({q, busy, tc, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_values: q=%0d busy=%b tc=%b done=%b, expected all zero",
                     q, busy, tc, done);
        end

        // start with q=0 must be ignored.
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        n_checks++;
        if (busy !== 1'b0 || q !== 4'd0) begin
            n_fail++;
            $display("FAIL start_with_zero: busy=%b q=%0d, expected busy=0 q=0", busy, q);
        end

        // Reset in the middle of a run aborts at once.
        step(1, 4'd6, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        async_reset_pulse();
        n_checks++;
        if ({q, busy, tc, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: q=%0d busy=%b tc=%b done=%b, expected all zero",
                     q, busy, tc, done);
        end
        release_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_one_shot();
        int tc_edge;
        tc_edge = -1;
        step(1, 4'd3, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        n_checks++;
        if (q !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL one_shot_start: q=%0d busy=%b, expected q=3 busy=1", q, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            step(0, 4'd0, 0, 0, 1, 0);
            if (tc === 1'b1) tc_edge = i;
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL one_shot edge%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
        end
        n_checks++;
        if (tc_edge != 3 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL one_shot_tc_timing: tc_edge=%0d done=%b busy=%b, expected tc_edge=3 done=1 busy=0",
                     tc_edge, done, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_periodic();
        int tc_count;
        tc_count = 0;
        step(1, 4'd2, 0, 0, 1, 1);
        step(0, 4'd0, 1, 0, 1, 1);
        for (int i = 1; i <= 9; i++) begin
            step(0, 4'd0, 0, 0, 1, 1);
            if (tc === 1'b1) tc_count++;
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL periodic edge%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
        end
        n_checks++;
        if (tc_count != 3 || q !== 4'd2) begin
            n_fail++;
            $display("FAIL periodic_tc_count: tc_count=%0d q=%0d, expected tc_count=3 q=2", tc_count, q);
        end
        // Clearing reload_en mid-period parks in DONE at the next zero.
        for (int i = 1; i <= 3; i++) begin
            step(0, 4'd0, 0, 0, 1, 0);
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL periodic_to_oneshot edge%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 4'd0) begin
            n_fail++;
            $display("FAIL periodic_stop_done: done=%b busy=%b q=%0d, expected done=1 busy=0 q=0",
                     done, busy, q);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause_gating();
        int tc_edge;
        tc_edge = -1;
        // en gating: preset 7, hold two edges at q=5, tc arrives 2 edges late.
        step(1, 4'd7, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        step(0, 4'd0, 0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 0, 0);
        n_checks++;
        if (q !== 4'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL gating_hold: q=%0d busy=%b tc=%b, expected q=5 busy=1 tc=0", q, busy, tc);
        end
        for (int i = 5; i <= 10; i++) begin
            step(0, 4'd0, 0, 0, 1, 0);
            if (tc === 1'b1) tc_edge = i;
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL gating edge%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
        end
        n_checks++;
        if (tc_edge != 9) begin
            n_fail++;
            $display("FAIL gating_tc_delay: tc at edge %0d, expected edge 9", tc_edge);
        end

        // stop at q=4, hold in IDLE, resume with start.
        step(1, 4'd6, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        step(0, 4'd0, 0, 1, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        n_checks++;
        if (q !== 4'd4 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_pause: q=%0d busy=%b done=%b, expected q=4 busy=0 done=0", q, busy, done);
        end
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        n_checks++;
        if (q !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_resume: q=%0d busy=%b, expected q=3 busy=1", q, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        step(1, 4'd5, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        step(1, 4'd9, 1, 1, 1, 0);
        n_checks++;
        if (q !== 4'd9 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority: q=%0d busy=%b done=%b tc=%b, expected q=9 busy=0 done=0 tc=0",
                     q, busy, done, tc);
        end
        step(0, 4'd0, 1, 1, 1, 0);
        step(0, 4'd0, 1, 1, 1, 0);
        n_checks++;
        if (q !== 4'd9 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle: q=%0d busy=%b, expected q=9 busy=0", q, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        // Preset 15 to DONE, then restart from DONE reloads 15.
        step(1, 4'd15, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        for (int i = 1; i <= 15; i++) step(0, 4'd0, 0, 0, 1, 0);
        n_checks++;
        if (q !== 4'd0 || done !== 1'b1 || tc !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max_preset_done: q=%0d done=%b tc=%b busy=%b, expected q=0 done=1 tc=1 busy=0",
                     q, done, tc, busy);
        end
        step(0, 4'd0, 1, 0, 1, 0);
        n_checks++;
        if (q !== 4'd15 || done !== 1'b0 || busy !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_from_done: q=%0d done=%b busy=%b tc=%b, expected q=15 done=0 busy=1 tc=0",
                     q, done, busy, tc);
        end
        for (int i = 1; i <= 15; i++) begin
            step(0, 4'd0, 0, 0, 1, 0);
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL restart_count edge%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
        end
        // Preset 1: tc on the very first enabled edge.
        step(1, 4'd1, 0, 0, 1, 0);
        step(0, 4'd0, 1, 0, 1, 0);
        step(0, 4'd0, 0, 0, 1, 0);
        n_checks++;
        if (tc !== 1'b1 || q !== 4'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL preset_one: tc=%b q=%0d done=%b, expected tc=1 q=0 done=1", tc, q, done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic       r_load;
        logic [3:0] r_d;
        logic       r_start;
        logic       r_stop;
        logic       r_en;
        logic       r_rel;
        r_rel = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r_load  = ($urandom_range(0, 11) == 0);
            r_d     = 4'($urandom_range(0, 15));
            r_start = ($urandom_range(0, 3) == 0);
            r_stop  = ($urandom_range(0, 19) == 0);
            r_en    = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 24) == 0) r_rel = ~r_rel;
            step(r_load, r_d, r_start, r_stop, r_en, r_rel);
            n_checks++;
            if (q !== m_q || busy !== m_running || tc !== m_tc || done !== m_done) begin
                n_fail++;
                $display("FAIL random cyc%0d: q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                         i, q, busy, tc, done, m_q, m_running, m_tc, m_done);
            end
            if ($urandom_range(0, 99) == 0) begin
                async_reset_pulse();
                n_checks++;
                if ({q, busy, tc, done} !== 7'b0) begin
                    n_fail++;
                    $display("FAIL random_reset cyc%0d: q=%0d busy=%b tc=%b done=%b, expected all zero",
                             i, q, busy, tc, done);
                end
                release_reset();
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause_gating();
        test_priority();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_down_counter_timer
